// File: rtl/uart_reg_bank_fifo.sv
// UART CPU-side register bank with TX/RX FIFOs, sticky W1C interrupt status and registered irq.
// Reads are combinational; pushes/pops land at the clock edge; full/empty FIFOs drop and flag in ISR.

module uart_rbf_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     din_i,
   output logic [W-1:0]     head_o,
   output logic [LVL_W-1:0] level_o
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] lvl_q;

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   // Callers gate push/pop against full/empty; pointers wrap naturally at power-of-2 depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         lvl_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push_i && !pop_i)      lvl_q <= lvl_q + LVL_W'(1);
         else if (pop_i && !push_i) lvl_q <= lvl_q - LVL_W'(1);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign level_o = lvl_q;
endmodule

module uart_reg_bank_fifo #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_e,
   input  logic              r_e,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic [DATA_W-1:0] r_data,
   output logic [DATA_W-1:0] MDR,
   output logic [DATA_W-1:0] DLL,
   output logic [DATA_W-1:0] DLH,
   output logic [DATA_W-1:0] LCR,
   output logic [DATA_W-1:0] IER,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              irq
);
   localparam logic [ADDR_W-1:0] A_MDR = ADDR_W'(0),  A_DLL = ADDR_W'(1), A_DLH = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_LCR = ADDR_W'(3),  A_IER = ADDR_W'(4), A_FSR = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_TBR = ADDR_W'(6),  A_RBR = ADDR_W'(7), A_ISR = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] A_TXL = ADDR_W'(9),  A_RXL = ADDR_W'(10);
   localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);

   logic [DATA_W-1:0] mdr_q, dll_q, dlh_q, lcr_q, ier_q, tbr_q, rx_head;
   logic [LVL_W-1:0]  tx_lvl, rx_lvl;
   logic [3:0]        isr_q, isr_d, isr_set, isr_clr;
   logic              irq_q;
   logic              tx_full, tx_empty, rx_full, rx_empty;
   logic              tbr_wr, tx_push, tx_pop, tx_ovf, tx_drain;
   logic              rbr_rd, rx_push, rx_pop, rx_ovf, rx_unf;

   assign tx_full  = (tx_lvl == LVL_FULL);
   assign tx_empty = (tx_lvl == '0);
   assign rx_full  = (rx_lvl == LVL_FULL);
   assign rx_empty = (rx_lvl == '0);

   assign tbr_wr   = w_e && (w_addr == A_TBR);
   assign tx_push  = tbr_wr && !tx_full;
   assign tx_ovf   = tbr_wr && tx_full;
   assign tx_pop   = tx_valid && tx_ready;
   assign tx_drain = (tx_lvl == LVL_W'(1)) && tx_pop && !tx_push;

   // A full RX FIFO still accepts a push when the CPU pops in the same cycle.
   assign rbr_rd   = r_e && (r_addr == A_RBR);
   assign rx_pop   = rbr_rd && !rx_empty;
   assign rx_unf   = rbr_rd && rx_empty;
   assign rx_push  = rx_valid && (!rx_full || rx_pop);
   assign rx_ovf   = rx_valid && !rx_push;

   uart_rbf_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_pop),
      .din_i(w_data), .head_o(tx_data), .level_o(tx_lvl)
   );

   uart_rbf_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(rx_push), .pop_i(rx_pop),
      .din_i(rx_data), .head_o(rx_head), .level_o(rx_lvl)
   );

   // Set events override a same-cycle W1C clear.
   assign isr_set = {rx_ovf | rx_unf, tx_ovf, rx_push, tx_drain};
   assign isr_clr = (w_e && (w_addr == A_ISR)) ? w_data[3:0] : 4'h0;
   assign isr_d   = (isr_q & ~isr_clr) | isr_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdr_q <= '0;
         dll_q <= '0;
         dlh_q <= '0;
         lcr_q <= '0;
         ier_q <= '0;
         tbr_q <= '0;
         isr_q <= '0;
         irq_q <= 1'b0;
      end else begin
         if (w_e && (w_addr == A_MDR)) mdr_q <= w_data & DATA_W'(8'h01);
         if (w_e && (w_addr == A_DLL)) dll_q <= w_data;
         if (w_e && (w_addr == A_DLH)) dlh_q <= w_data;
         if (w_e && (w_addr == A_LCR)) lcr_q <= w_data & DATA_W'(8'h3F);
         if (w_e && (w_addr == A_IER)) ier_q <= w_data & DATA_W'(8'h0F);
         if (tbr_wr) tbr_q <= w_data;
         isr_q <= isr_d;
         irq_q <= |(isr_d & ier_q[3:0]);
      end
   end

   always_comb begin
      r_data = '0;
      case (r_addr)
         A_MDR: r_data = mdr_q;
         A_DLL: r_data = dll_q;
         A_DLH: r_data = dlh_q;
         A_LCR: r_data = lcr_q;
         A_IER: r_data = ier_q;
         A_FSR: r_data[3:0] = {rx_full, rx_empty, tx_full, tx_empty};
         A_TBR: r_data = tbr_q;
         A_RBR: if (!rx_empty) r_data = rx_head;
         A_ISR: r_data[3:0] = isr_q;
         A_TXL: r_data[LVL_W-1:0] = tx_lvl;
         A_RXL: r_data[LVL_W-1:0] = rx_lvl;
         default: r_data = '0;
      endcase
   end

   assign MDR      = mdr_q;
   assign DLL      = dll_q;
   assign DLH      = dlh_q;
   assign LCR      = lcr_q;
   assign IER      = ier_q;
   assign tx_valid = !tx_empty;
   assign irq      = irq_q;
endmodule

// File: tb/tb_uart_reg_bank_fifo.sv
// Directed bench for uart_reg_bank_fifo: inputs change just after negedge, outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_uart_reg_bank_fifo;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       w_e = 1'b0, r_e = 1'b0;
   logic [7:0] w_addr = '0, r_addr = '0, w_data = '0, rx_data = '0;
   logic [7:0] r_data, MDR, DLL, DLH, LCR, IER, tx_data;
   logic       tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, irq;
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   uart_reg_bank_fifo dut (
      .clk(clk), .rst_n(rst_n), .w_e(w_e), .r_e(r_e), .w_addr(w_addr), .r_addr(r_addr),
      .w_data(w_data), .r_data(r_data), .MDR(MDR), .DLL(DLL), .DLH(DLH), .LCR(LCR), .IER(IER),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      w_e = 1'b1; w_addr = a; w_data = d;
      @(negedge clk);
      w_e = 1'b0;
   endtask

   task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string tag);
      r_addr = a;
      #1;
      chk(tag, r_data, exp);
   endtask

   task automatic pop_rbr(input logic [7:0] exp, input string tag);
      r_e = 1'b1; r_addr = 8'd7;
      #1;
      chk(tag, r_data, exp);
      @(negedge clk);
      r_e = 1'b0;
   endtask

   task automatic rxpush(input logic [7:0] d);
      rx_valid = 1'b1; rx_data = d;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_rst [11];
      exp_rst = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset state
      for (int a = 0; a < 11; a++) peek(8'(a), exp_rst[a], $sformatf("rst_addr%0d", a));
      peek(8'd11, 8'h00, "unmapped_rd");
      chk("rst_irq", irq, 0);
      chk("rst_tx_valid", tx_valid, 0);

      // configuration masks
      wr(8'd0, 8'hFF); wr(8'd3, 8'hFF); wr(8'd4, 8'hFF);
      wr(8'd1, 8'hA5); wr(8'd2, 8'h5A); wr(8'd11, 8'hFF);
      peek(8'd0, 8'h01, "mdr_mask");
      peek(8'd3, 8'h3F, "lcr_mask");
      peek(8'd4, 8'h0F, "ier_mask");
      peek(8'd1, 8'hA5, "dll_full");
      peek(8'd2, 8'h5A, "dlh_full");
      chk("mdr_port", MDR, 8'h01);
      chk("lcr_port", LCR, 8'h3F);
      peek(8'd11, 8'h00, "unmapped_wr_ignored");
      wr(8'd4, 8'h00);

      // TX fill to full, overflow, drain
      for (int i = 0; i < 16; i++) wr(8'd6, 8'(i));
      peek(8'd6, 8'h0F, "tbr_last");
      wr(8'd6, 8'h10);
      peek(8'd9, 8'h10, "txlvl_full");
      peek(8'd5, 8'h06, "fsr_tx_full");
      peek(8'd8, 8'h04, "isr_tx_ovf");
      chk("tx_valid_full", tx_valid, 1);
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk($sformatf("tx_data%0d", i), tx_data, 32'(i));
         @(negedge clk);
      end
      tx_ready = 1'b0;
      peek(8'd8, 8'h05, "isr_tx_drained");
      peek(8'd9, 8'h00, "txlvl_empty");
      chk("tx_valid_empty", tx_valid, 0);
      wr(8'd8, 8'h0F);
      peek(8'd8, 8'h00, "isr_cleared");

      // RX push/pop and underflow
      rxpush(8'hA5); rxpush(8'h3C);
      peek(8'd10, 8'h02, "rxlvl2");
      peek(8'd5, 8'h01, "fsr_rx_nonempty");
      pop_rbr(8'hA5, "rbr0");
      pop_rbr(8'h3C, "rbr1");
      pop_rbr(8'h00, "rbr_underflow");
      peek(8'd8, 8'h0A, "isr_rx_unf");
      wr(8'd8, 8'h0F);

      // RX full with simultaneous push and pop
      for (int i = 0; i < 16; i++) rxpush(8'(8'h10 + i));
      peek(8'd10, 8'h10, "rxlvl_full");
      peek(8'd5, 8'h09, "fsr_rx_full");
      wr(8'd8, 8'h0F);
      rx_valid = 1'b1; rx_data = 8'h77; r_e = 1'b1; r_addr = 8'd7;
      #1;
      chk("rbr_full_pop", r_data, 8'h10);
      @(negedge clk);
      rx_valid = 1'b0; r_e = 1'b0;
      peek(8'd10, 8'h10, "rxlvl_still_full");
      peek(8'd8, 8'h02, "isr_no_rx_ovf");
      for (int i = 1; i < 16; i++) pop_rbr(8'(8'h10 + i), $sformatf("rbr_drain%0d", i));
      pop_rbr(8'h77, "rbr_last_77");
      peek(8'd10, 8'h00, "rxlvl_drained");
      wr(8'd8, 8'h0F);

      // irq timing and set-beats-clear
      wr(8'd4, 8'h02);
      rx_valid = 1'b1; rx_data = 8'h42;
      #1;
      chk("irq_before_edge", irq, 0);
      @(negedge clk);
      rx_valid = 1'b0;
      #1;
      chk("irq_after_push", irq, 1);
      w_e = 1'b1; w_addr = 8'd8; w_data = 8'h02; rx_valid = 1'b1; rx_data = 8'h43;
      @(negedge clk);
      w_e = 1'b0; rx_valid = 1'b0;
      peek(8'd8, 8'h02, "isr_set_wins");
      chk("irq_held", irq, 1);
      wr(8'd8, 8'h02);
      #1;
      chk("irq_cleared", irq, 0);
      peek(8'd8, 8'h00, "isr_w1c");
      peek(8'd10, 8'h02, "rxlvl_after_irq");
      peek(8'd4, 8'h02, "ier_kept");

      // reset mid-operation
      wr(8'd6, 8'h99);
      rxpush(8'h55);
      #1;
      chk("irq_pre_reset", irq, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_irq", irq, 0);
      chk("rst_mid_tx_valid", tx_valid, 0);
      peek(8'd10, 8'h00, "rst_mid_rxlvl");
      peek(8'd8, 8'h00, "rst_mid_isr");
      peek(8'd5, 8'h05, "rst_mid_fsr");
      @(negedge clk);
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
